hamming_dist_accum: RTL and testbench

HAMMING_DIST_ACCUM -- requirements
Module: hamming_dist_accum

---
 rtl/hamming_dist_accum_pkg.sv | 5 +
 rtl/hamming_dist_accum.sv | 84 ++++++++
 tb/tb_hamming_dist_accum.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hamming_dist_accum_pkg.sv
// hamming_dist_accum_pkg: shared FSM state encoding and per-word distance width
package hamming_dist_accum_pkg;
    localparam int DIST_W = 6;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/hamming_dist_accum.sv
// hamming_dist_accum: sums per-word Hamming distances over a frame and flags threshold match / truncation
module hamming_dist_accum
    import hamming_dist_accum_pkg::*;
#(
    parameter int MAX_WORDS = 16,
    parameter int SUM_W = 6 + $clog2(MAX_WORDS),
    localparam int CNT_W = $clog2(MAX_WORDS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIST_W-1:0] in_dist,
    input  logic              in_last,
    input  logic [SUM_W-1:0]  thresh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_match,
    output logic              out_ovf
);
    state_t           state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d, sum_n;
    logic [SUM_W-1:0] thr_q, thr_d, thr_n;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
    logic             match_q, match_d, ovf_q, ovf_d;
    logic             acc, first, full;

    // Gated by rst so the block advertises nothing while held in reset
    assign in_ready = rst && state_q != DONE;
    assign acc      = in_valid && in_ready;
    assign first    = state_q == IDLE;
    assign sum_n    = (first ? '0 : sum_q) + SUM_W'(in_dist);
    assign cnt_n    = (first ? '0 : cnt_q) + CNT_W'(1);
    assign thr_n    = first ? thresh : thr_q;
    assign full     = cnt_n == CNT_W'(MAX_WORDS);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        match_d = match_q;
        ovf_d   = ovf_q;
        if (acc) begin
            sum_d   = sum_n;
            cnt_d   = cnt_n;
            thr_d   = thr_n;
            match_d = sum_n <= thr_n;
            ovf_d   = full && !in_last;
            state_d = (in_last || full) ? DONE : ACCUM;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            thr_q   <= '0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = state_q == DONE;
    assign out_sum   = sum_q;
    assign out_count = cnt_q;
    assign out_match = match_q;
    assign out_ovf   = ovf_q;

    // Distances above 32 cannot come from a 32-bit XOR popcount
    assert property (@(posedge clk) disable iff (!rst) !acc || in_dist <= 6'd32);
endmodule

// File: tb/tb_hamming_dist_accum.sv
// tb_hamming_dist_accum: table-driven frames plus corner sequences, checked through an expected-result queue
module tb_hamming_dist_accum;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_dist = '0;
    logic       in_last = 1'b0;
    logic [9:0] thresh = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [9:0] out_sum;
    logic [4:0] out_count;
    logic       out_match;
    logic       out_ovf;

    int n_run = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [9:0] sum;
        logic [4:0] cnt;
        logic       m;
        logic       o;
    } exp_t;

    typedef struct {
        string      nm;
        int         n;
        int         gap;
        logic [5:0] d [4];
        logic [9:0] th;
        logic [9:0] sum;
        logic [4:0] cnt;
        logic       m;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    hamming_dist_accum dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist), .in_last(in_last), .thresh(thresh),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
        .out_match(out_match), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input int n, input int gap, input logic [5:0] d0, input logic [5:0] d1,
                       input logic [5:0] d2, input logic [5:0] d3, input logic [9:0] th, input logic [9:0] sum,
                       input logic [4:0] cnt, input logic m);
        vec_t v;
        v.nm = nm; v.n = n; v.gap = gap;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.th = th; v.sum = sum; v.cnt = cnt; v.m = m;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [5:0] d, input logic l, input logic [9:0] th);
        int t;
        t = 0;
        in_valid = 1'b1; in_dist = d; in_last = l; thresh = th;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_run++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string nm);
        int t;
        exp_t e;
        t = 0;
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_valid"}, 32'(out_valid), 1);
        chk({nm, "_latency"}, t, 0);
        chk({nm, "_in_ready_done"}, 32'(in_ready), 0);
        if (sb.size() == 0) begin
            chk({nm, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({nm, "_sum"}, 32'(out_sum), 32'(e.sum));
            chk({nm, "_count"}, 32'(out_count), 32'(e.cnt));
            chk({nm, "_match"}, 32'(out_match), 32'(e.m));
            chk({nm, "_ovf"}, 32'(out_ovf), 32'(e.o));
        end
        if (out_ready) begin
            @(negedge clk);
            chk({nm, "_idle_valid"}, 32'(out_valid), 0);
            chk({nm, "_idle_ready"}, 32'(in_ready), 1);
        end
    endtask

    initial begin
        add("single", 1, -1, 6'd7, 0, 0, 0, 10'd7, 10'd7, 5'd1, 1'b1);
        add("four_gap", 4, 1, 6'd32, 6'd0, 6'd5, 6'd10, 10'd40, 10'd47, 5'd4, 1'b0);
        add("zeros_eq", 2, -1, 6'd0, 6'd0, 0, 0, 10'd0, 10'd0, 5'd2, 1'b1);
        add("thr_below", 3, -1, 6'd32, 6'd32, 6'd32, 0, 10'd95, 10'd96, 5'd3, 1'b0);
        add("thr_equal", 3, 0, 6'd32, 6'd32, 6'd32, 0, 10'd96, 10'd96, 5'd3, 1'b1);
        add("zero_max", 1, -1, 6'd0, 0, 0, 0, 10'd1023, 10'd0, 5'd1, 1'b1);
        add("ramp", 4, 2, 6'd1, 6'd2, 6'd3, 6'd4, 10'd9, 10'd10, 5'd4, 1'b0);

        rst = 1'b1;
        #1 rst = 1'b0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(out_sum), 0);
        chk("rst_count", 32'(out_count), 0);
        chk("rst_match", 32'(out_match), 0);
        chk("rst_ovf", 32'(out_ovf), 0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rel_in_ready", 32'(in_ready), 1);
        @(negedge clk);

        foreach (vecs[i]) begin
            sb.push_back('{sum: vecs[i].sum, cnt: vecs[i].cnt, m: vecs[i].m, o: 1'b0});
            for (int w = 0; w < vecs[i].n; w++) begin
                drive(vecs[i].d[w], w == vecs[i].n - 1, vecs[i].th);
                if (w == vecs[i].gap) @(negedge clk);
            end
            get_result(vecs[i].nm);
        end

        sb.push_back('{sum: 10'd512, cnt: 5'd16, m: 1'b1, o: 1'b1});
        for (int w = 0; w < 16; w++) drive(6'd32, 1'b0, 10'd600);
        get_result("trunc");
        sb.push_back('{sum: 10'd5, cnt: 5'd1, m: 1'b0, o: 1'b0});
        drive(6'd5, 1'b1, 10'd3);
        get_result("after_trunc");

        out_ready = 1'b0;
        sb.push_back('{sum: 10'd9, cnt: 5'd1, m: 1'b1, o: 1'b0});
        drive(6'd9, 1'b1, 10'd20);
        get_result("bp");
        in_valid = 1'b1; in_dist = 6'd1; in_last = 1'b1; thresh = 10'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_ready", 32'(in_ready), 0);
            chk("bp_hold_sum", 32'(out_sum), 9);
            chk("bp_hold_count", 32'(out_count), 1);
            chk("bp_hold_match", 32'(out_match), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 0);
        chk("bp_release_ready", 32'(in_ready), 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_no_consume", 32'(out_valid), 0);
        sb.push_back('{sum: 10'd4, cnt: 5'd1, m: 1'b1, o: 1'b0});
        drive(6'd4, 1'b1, 10'd4);
        get_result("post_bp");

        for (int w = 0; w < 3; w++) drive(6'd10, 1'b0, 10'd50);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_sum", 32'(out_sum), 0);
        chk("mid_rst_count", 32'(out_count), 0);
        chk("mid_rst_match", 32'(out_match), 0);
        chk("mid_rst_ovf", 32'(out_ovf), 0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("mid_rel_ready", 32'(in_ready), 1);
        @(negedge clk);
        sb.push_back('{sum: 10'd3, cnt: 5'd1, m: 1'b1, o: 1'b0});
        drive(6'd3, 1'b1, 10'd3);
        get_result("post_rst");

        sb.push_back('{sum: 10'd50, cnt: 5'd3, m: 1'b0, o: 1'b0});
        drive(6'd20, 1'b0, 10'd10);
        drive(6'd20, 1'b0, 10'd100);
        drive(6'd10, 1'b1, 10'd100);
        get_result("thr_latch");

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
